// File: rtl/mem_dp_param.sv
// rtl/mem_dp_param.sv - 1W/2R synchronous memory with byte enables and fill sequencer
// Reads are registered; READ_MODE picks old or merged data on a read/write collision.
module mem_dp_param #(
  parameter int               DSIZE     = 16,
  parameter int               ASIZE     = 10,
  parameter int               READ_MODE = 0,
  parameter logic [DSIZE-1:0] INIT_VAL  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_start,
  output logic               init_busy,
  output logic               init_done,
  input  logic               wen,
  input  logic [DSIZE/8-1:0] wbe,
  input  logic [ASIZE-1:0]   waddr,
  input  logic [DSIZE-1:0]   wdata,
  input  logic [ASIZE-1:0]   raddr_a,
  output logic [DSIZE-1:0]   rdata_a,
  input  logic [ASIZE-1:0]   raddr_b,
  output logic [DSIZE-1:0]   rdata_b
);

  localparam int               NBYTES  = DSIZE / 8;
  localparam int               DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE-1:0] CNT_ONE = 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state_q, state_d;
  logic [ASIZE-1:0] cnt_q, cnt_d;
  logic [DSIZE-1:0] rdata_a_q, rdata_a_d;
  logic [DSIZE-1:0] rdata_b_q, rdata_b_d;
  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [DSIZE-1:0] old_a, old_b, merged_a, merged_b;
  logic             wr_en;
  logic             fill_last;

  assign wr_en     = wen && (state_q == IDLE);
  assign fill_last = (state_q == FILL) && (&cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        cnt_d = cnt_q + CNT_ONE;
        if (&cnt_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Merged words are what the array will hold after this edge's write.
  always_comb begin
    old_a    = mem_q[raddr_a];
    old_b    = mem_q[raddr_b];
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NBYTES; i++) begin
      if (wbe[i]) begin
        merged_a[8*i +: 8] = wdata[8*i +: 8];
        merged_b[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_a_d = old_a;
    rdata_b_d = old_b;
    if (state_q == FILL) begin
      rdata_a_d = INIT_VAL;
      rdata_b_d = INIT_VAL;
    end else if (READ_MODE != 0 && wr_en) begin
      if (raddr_a == waddr) rdata_a_d = merged_a;
      if (raddr_b == waddr) rdata_b_d = merged_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Array is deliberately outside the reset domain; only the fill sequencer initialises it.
  always_ff @(posedge clk) begin
    if (state_q == FILL) begin
      mem_q[cnt_q] <= INIT_VAL;
    end else if (wen) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign init_busy = (state_q == FILL);
  assign init_done = fill_last;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;

endmodule

// File: tb/tb_mem_dp_param.sv
// tb/tb_mem_dp_param.sv - directed bench for mem_dp_param (read-first and write-first builds)
module tb_mem_dp_param;

  localparam logic [15:0] IV = 16'hA5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Instance A: ASIZE=10, read-first
  logic        a_rst, a_start, a_busy, a_done, a_wen;
  logic [1:0]  a_wbe;
  logic [9:0]  a_waddr, a_raddr_a, a_raddr_b;
  logic [15:0] a_wdata, a_rdata_a, a_rdata_b;

  // Instance B: ASIZE=4, write-first, INIT_VAL=A5A5
  logic        b_rst, b_start, b_busy, b_done, b_wen;
  logic [1:0]  b_wbe;
  logic [3:0]  b_waddr, b_raddr_a, b_raddr_b;
  logic [15:0] b_wdata, b_rdata_a, b_rdata_b;

  mem_dp_param #(.DSIZE(16), .ASIZE(10), .READ_MODE(0), .INIT_VAL(16'h0000)) dut_a (
    .clk(clk), .rst(a_rst), .init_start(a_start), .init_busy(a_busy), .init_done(a_done),
    .wen(a_wen), .wbe(a_wbe), .waddr(a_waddr), .wdata(a_wdata),
    .raddr_a(a_raddr_a), .rdata_a(a_rdata_a), .raddr_b(a_raddr_b), .rdata_b(a_rdata_b)
  );

  mem_dp_param #(.DSIZE(16), .ASIZE(4), .READ_MODE(1), .INIT_VAL(IV)) dut_b (
    .clk(clk), .rst(b_rst), .init_start(b_start), .init_busy(b_busy), .init_done(b_done),
    .wen(b_wen), .wbe(b_wbe), .waddr(b_waddr), .wdata(b_wdata),
    .raddr_a(b_raddr_a), .rdata_a(b_rdata_a), .raddr_b(b_raddr_b), .rdata_b(b_rdata_b)
  );

  task automatic wr_a(input logic [9:0] ad, input logic [15:0] d, input logic [1:0] be);
    a_wen = 1'b1; a_waddr = ad; a_wdata = d; a_wbe = be;
    @(posedge clk); #1;
    a_wen = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] ad, input logic [15:0] d, input logic [1:0] be);
    b_wen = 1'b1; b_waddr = ad; b_wdata = d; b_wbe = be;
    @(posedge clk); #1;
    b_wen = 1'b0;
  endtask

  task automatic rd_a(input logic [9:0] ad_a, input logic [9:0] ad_b);
    a_raddr_a = ad_a; a_raddr_b = ad_b;
    @(posedge clk); #1;
  endtask

  task automatic rd_b(input logic [3:0] ad_a, input logic [3:0] ad_b);
    b_raddr_a = ad_a; b_raddr_b = ad_b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_rdata_a !== 16'h0 || a_rdata_b !== 16'h0)
      begin fails++; $display("FAIL reset_a_rdata: got %h/%h expected 0000/0000", a_rdata_a, a_rdata_b); end
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0)
      begin fails++; $display("FAIL reset_a_flags: got busy=%b done=%b expected 0/0", a_busy, a_done); end
    checks++;
    if (b_rdata_a !== 16'h0 || b_rdata_b !== 16'h0)
      begin fails++; $display("FAIL reset_b_rdata: got %h/%h expected 0000/0000", b_rdata_a, b_rdata_b); end
    checks++;
    if (b_busy !== 1'b0 || b_done !== 1'b0)
      begin fails++; $display("FAIL reset_b_flags: got busy=%b done=%b expected 0/0", b_busy, b_done); end
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    wr_a(10'h005, 16'hBEEF, 2'b11);
    rd_a(10'h005, 10'h005);
    checks++;
    if (a_rdata_a !== 16'hBEEF || a_rdata_b !== 16'hBEEF)
      begin fails++; $display("FAIL write_read: got %h/%h expected beef/beef", a_rdata_a, a_rdata_b); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wr_a(10'h100 + 10'(i), 16'hC000 + 16'(i), 2'b11);
    for (int i = 0; i < 4; i++) begin
      rd_a(10'h100 + 10'(i), 10'h103 - 10'(i));
      checks++;
      if (a_rdata_a !== 16'hC000 + 16'(i) || a_rdata_b !== 16'hC003 - 16'(i))
        begin fails++; $display("FAIL back_to_back[%0d]: got %h/%h expected %h/%h", i, a_rdata_a, a_rdata_b, 16'hC000 + 16'(i), 16'hC003 - 16'(i)); end
    end
  endtask

  task automatic test_byte_enable();
    wr_a(10'h010, 16'h1234, 2'b11);
    wr_a(10'h010, 16'hABCD, 2'b01);
    rd_a(10'h010, 10'h010);
    checks++;
    if (a_rdata_a !== 16'h12CD)
      begin fails++; $display("FAIL be_low: got %h expected 12cd", a_rdata_a); end
    wr_a(10'h010, 16'hFFFF, 2'b00);
    rd_a(10'h010, 10'h010);
    checks++;
    if (a_rdata_a !== 16'h12CD)
      begin fails++; $display("FAIL be_none: got %h expected 12cd", a_rdata_a); end
    wr_a(10'h010, 16'h9900, 2'b10);
    rd_a(10'h010, 10'h010);
    checks++;
    if (a_rdata_b !== 16'h99CD)
      begin fails++; $display("FAIL be_high: got %h expected 99cd", a_rdata_b); end
  endtask

  task automatic test_collision_read_first();
    wr_a(10'h020, 16'h1111, 2'b11);
    a_raddr_a = 10'h020; a_raddr_b = 10'h020;
    wr_a(10'h020, 16'h5555, 2'b11);
    checks++;
    if (a_rdata_a !== 16'h1111 || a_rdata_b !== 16'h1111)
      begin fails++; $display("FAIL coll_rf: got %h/%h expected 1111/1111", a_rdata_a, a_rdata_b); end
    @(posedge clk); #1;
    checks++;
    if (a_rdata_a !== 16'h5555 || a_rdata_b !== 16'h5555)
      begin fails++; $display("FAIL coll_rf_after: got %h/%h expected 5555/5555", a_rdata_a, a_rdata_b); end
  endtask

  task automatic test_collision_write_first();
    wr_b(4'h2, 16'h1111, 2'b11);
    b_raddr_a = 4'h2; b_raddr_b = 4'h2;
    wr_b(4'h2, 16'h5555, 2'b11);
    checks++;
    if (b_rdata_a !== 16'h5555 || b_rdata_b !== 16'h5555)
      begin fails++; $display("FAIL coll_wf: got %h/%h expected 5555/5555", b_rdata_a, b_rdata_b); end
    wr_b(4'h2, 16'h7777, 2'b01);
    checks++;
    if (b_rdata_a !== 16'h5577 || b_rdata_b !== 16'h5577)
      begin fails++; $display("FAIL coll_wf_merge: got %h/%h expected 5577/5577", b_rdata_a, b_rdata_b); end
  endtask

  task automatic test_fill();
    int busy_cycles, done_cnt;
    logic prev_busy;
    busy_cycles = 0; done_cnt = 0; prev_busy = 1'b0;
    for (int i = 0; i < 16; i++) wr_b(4'(i), 16'h1000 + 16'(i), 2'b11);
    b_start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b_busy !== 1'b1)
      begin fails++; $display("FAIL fill_busy_start: got %b expected 1", b_busy); end
    for (int c = 0; c < 40 && b_busy === 1'b1; c++) begin
      busy_cycles++;
      if (b_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (busy_cycles != 16)
          begin fails++; $display("FAIL fill_done_pos: got cycle %0d expected 16", busy_cycles); end
      end
      if (prev_busy) begin
        checks++;
        if (b_rdata_a !== IV || b_rdata_b !== IV)
          begin fails++; $display("FAIL fill_rdata[%0d]: got %h/%h expected a5a5", c, b_rdata_a, b_rdata_b); end
      end
      prev_busy = 1'b1;
      b_start = 1'b1; b_wen = 1'b1; b_wbe = 2'b11; b_waddr = 4'(c); b_wdata = 16'h0BAD;
      b_raddr_a = 4'(c); b_raddr_b = 4'(15 - c);
      @(posedge clk); #1;
    end
    b_start = 1'b0; b_wen = 1'b0;
    checks++;
    if (busy_cycles != 16)
      begin fails++; $display("FAIL fill_busy_len: got %0d expected 16", busy_cycles); end
    checks++;
    if (done_cnt != 1)
      begin fails++; $display("FAIL fill_done_cnt: got %0d expected 1", done_cnt); end
    for (int i = 0; i < 16; i++) begin
      rd_b(4'(i), 4'(15 - i));
      checks++;
      if (b_rdata_a !== IV || b_rdata_b !== IV)
        begin fails++; $display("FAIL fill_content[%0d]: got %h/%h expected a5a5", i, b_rdata_a, b_rdata_b); end
    end
    checks++;
    if (b_busy !== 1'b0)
      begin fails++; $display("FAIL fill_no_restart: got busy=%b expected 0", b_busy); end
  endtask

  task automatic test_fill_abort();
    int done_cnt;
    logic [15:0] exp;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) wr_b(4'(i), 16'h2000 + 16'(i), 2'b11);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (b_done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    b_rst = 1'b1;
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_done !== 1'b0)
      begin fails++; $display("FAIL abort_flags: got busy=%b done=%b expected 0/0", b_busy, b_done); end
    checks++;
    if (b_rdata_a !== 16'h0 || b_rdata_b !== 16'h0)
      begin fails++; $display("FAIL abort_rdata: got %h/%h expected 0000/0000", b_rdata_a, b_rdata_b); end
    checks++;
    if (done_cnt != 0)
      begin fails++; $display("FAIL abort_done_seen: got %0d expected 0", done_cnt); end
    @(posedge clk); #1;
    b_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 7) ? IV : 16'h2000 + 16'(i);
      rd_b(4'(i), 4'(i));
      checks++;
      if (b_rdata_a !== exp || b_rdata_b !== exp)
        begin fails++; $display("FAIL abort_content[%0d]: got %h/%h expected %h", i, b_rdata_a, b_rdata_b, exp); end
    end
  endtask

  task automatic test_start_with_write();
    int busy_cycles;
    wr_b(4'h3, 16'h3333, 2'b11);
    b_wen = 1'b1; b_waddr = 4'h3; b_wdata = 16'h0F0F; b_wbe = 2'b11; b_start = 1'b1;
    @(posedge clk); #1;
    b_wen = 1'b0; b_start = 1'b0;
    checks++;
    if (b_busy !== 1'b1)
      begin fails++; $display("FAIL start_wr_busy: got %b expected 1", b_busy); end
    @(posedge clk); #1;
    b_rst = 1'b1; #1; b_rst = 1'b0;
    rd_b(4'h3, 4'h3);
    checks++;
    if (b_rdata_a !== 16'h0F0F || b_rdata_b !== 16'h0F0F)
      begin fails++; $display("FAIL start_wr_done: got %h/%h expected 0f0f", b_rdata_a, b_rdata_b); end
    b_wen = 1'b1; b_waddr = 4'h3; b_wdata = 16'h7E7E; b_wbe = 2'b11; b_start = 1'b1;
    @(posedge clk); #1;
    b_wen = 1'b0; b_start = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 40 && b_busy === 1'b1; c++) begin
      busy_cycles++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_cycles != 16)
      begin fails++; $display("FAIL start_wr_fill_len: got %0d expected 16", busy_cycles); end
    rd_b(4'h3, 4'h3);
    checks++;
    if (b_rdata_a !== IV || b_rdata_b !== IV)
      begin fails++; $display("FAIL start_wr_final: got %h/%h expected a5a5", b_rdata_a, b_rdata_b); end
  endtask

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_wen = 1'b0; a_wbe = 2'b00; a_waddr = '0; a_wdata = '0;
    a_raddr_a = '0; a_raddr_b = '0;
    b_rst = 1'b1; b_start = 1'b0; b_wen = 1'b0; b_wbe = 2'b00; b_waddr = '0; b_wdata = '0;
    b_raddr_a = '0; b_raddr_b = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_byte_enable();
    test_collision_read_first();
    test_collision_write_first();
    test_fill();
    test_fill_abort();
    test_start_with_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
